// File: rtl/mix_addkey_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mix_addkey_stage_if: upstream, downstream and Rcon loop signals    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mix_addkey_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [127:0] g_in;
  logic [127:0] h_in;
  logic [127:0] t_in;
  logic [127:0] rkey_in;
  logic [7:0]   rcon_next;
  logic [7:0]   rcon_o;
  logic [3:0]   round_o;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         out_last;

  modport master (
    output in_valid, in_first, g_in, h_in, t_in, rkey_in, rcon_next, out_ready,
    input  in_ready, rcon_o, round_o, out_valid, state_out, out_last
  );

  modport slave (
    input  in_valid, in_first, g_in, h_in, t_in, rkey_in, rcon_next, out_ready,
    output in_ready, rcon_o, round_o, out_valid, state_out, out_last
  );
endinterface
`default_nettype wire

// File: rtl/mix_addkey_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mix_addkey_stage: AES MixColumns + AddRoundKey output register     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mix_addkey_stage #(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_INIT = 8'h01
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mix_addkey_stage_if.slave bus
);

  localparam logic [3:0] c_NR = 4'(NR);

  logic         out_valid_q;
  logic         last_q;
  logic [127:0] state_q;
  logic [3:0]   round_q;
  logic [7:0]   rcon_q;

  logic         w_in_ready;
  logic         w_acc;
  logic         w_last;
  logic [3:0]   w_round;
  logic [127:0] w_mix;
  logic [127:0] state_d;

  assign w_in_ready = !out_valid_q | bus.out_ready;
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_round    = bus.in_first ? 4'd1 : round_q;
  assign w_last     = (w_round == c_NR);

  // Byte k of column c sits at bit 127-32c-8k; h carries 2a, t carries 3a.
  for (genvar c = 0; c < 4; c++) begin : g_col
    localparam int c_B0 = 127 - 32*c;
    localparam int c_B1 = c_B0 - 8;
    localparam int c_B2 = c_B0 - 16;
    localparam int c_B3 = c_B0 - 24;
    assign w_mix[c_B0 -: 8] = bus.h_in[c_B0 -: 8] ^ bus.t_in[c_B1 -: 8]
                            ^ bus.g_in[c_B2 -: 8] ^ bus.g_in[c_B3 -: 8];
    assign w_mix[c_B1 -: 8] = bus.g_in[c_B0 -: 8] ^ bus.h_in[c_B1 -: 8]
                            ^ bus.t_in[c_B2 -: 8] ^ bus.g_in[c_B3 -: 8];
    assign w_mix[c_B2 -: 8] = bus.g_in[c_B0 -: 8] ^ bus.g_in[c_B1 -: 8]
                            ^ bus.h_in[c_B2 -: 8] ^ bus.t_in[c_B3 -: 8];
    assign w_mix[c_B3 -: 8] = bus.t_in[c_B0 -: 8] ^ bus.g_in[c_B1 -: 8]
                            ^ bus.g_in[c_B2 -: 8] ^ bus.h_in[c_B3 -: 8];
  end

  // The final round skips MixColumns.
  assign state_d = (w_last ? bus.g_in : w_mix) ^ bus.rkey_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      state_q     <= '0;
      round_q     <= 4'd1;
      rcon_q      <= RCON_INIT;
    end else begin
      if (w_acc) begin
        out_valid_q <= 1'b1;
        last_q      <= w_last;
        state_q     <= state_d;
        if (w_last) begin
          round_q <= 4'd1;
          rcon_q  <= RCON_INIT;
        end else begin
          round_q <= w_round + 4'd1;
          rcon_q  <= bus.rcon_next;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = last_q;
  assign bus.state_out = state_q;
  assign bus.round_o   = round_q;
  assign bus.rcon_o    = rcon_q;

endmodule
`default_nettype wire

// File: tb/tb_mix_addkey_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mix_addkey_stage: random + directed bench with GF(2^8) model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mix_addkey_stage;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mix_addkey_stage_if bus();

  mix_addkey_stage #(.NR(NR), .RCON_INIT(8'h01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic         m_valid;
  logic         m_last;
  logic [127:0] m_state;
  int           m_round;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] x = 8'h01;
    for (int i = 1; i < r; i++) x = xt(x);
    return x;
  endfunction

  // MixColumns matrix is circulant over (2,3,1,1).
  function automatic int coef(input int row, input int k);
    int d = (k - row + 4) % 4;
    return (d == 0) ? 2 : (d == 1) ? 3 : 1;
  endfunction

  function automatic logic [127:0] mixcols(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        logic [7:0] acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(s[127 - 8*(4*c + k) -: 8], coef(row, k));
        o[127 - 8*(4*c + row) -: 8] = acc;
      end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_state = '0;
    m_round = 1;
  endtask

  task automatic drive(input logic v, input logic f, input logic rdy);
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.out_ready = rdy;
    bus.g_in      = {$urandom, $urandom, $urandom, $urandom};
    bus.rkey_in   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One clock: settle, compare against the model, advance the model, cross the edge.
  task automatic step();
    logic ready, acc;
    int r;
    for (int i = 0; i < 16; i++) begin
      bus.h_in[127 - 8*i -: 8] = gmul(bus.g_in[127 - 8*i -: 8], 2);
      bus.t_in[127 - 8*i -: 8] = gmul(bus.g_in[127 - 8*i -: 8], 3);
    end
    ready = !m_valid | bus.out_ready;
    acc   = bus.in_valid & ready;
    r     = bus.in_first ? 1 : m_round;
    bus.rcon_next = acc ? xt(rcon_of(r)) : 8'($urandom);
    #1;
    check("in_ready",  128'(bus.in_ready),  128'(ready));
    check("round_o",   128'(bus.round_o),   128'(m_round));
    check("rcon_o",    128'(bus.rcon_o),    128'(rcon_of(m_round)));
    check("out_valid", 128'(bus.out_valid), 128'(m_valid));
    check("state_out", bus.state_out,       m_state);
    check("out_last",  128'(bus.out_last),  128'(m_last));
    if (acc) begin
      m_state = ((r == NR) ? bus.g_in : mixcols(bus.g_in)) ^ bus.rkey_in;
      m_last  = (r == NR);
      m_valid = 1'b1;
      m_round = (r == NR) ? 1 : r + 1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    drive(1'b0, 1'b0, 1'b0);
    bus.h_in = '0;
    bus.t_in = '0;
    bus.rcon_next = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 128'(bus.out_valid), 128'(0));
    check("rst_state", bus.state_out,       128'(0));
    check("rst_last",  128'(bus.out_last),  128'(0));
    check("rst_round", 128'(bus.round_o),   128'(1));
    check("rst_rcon",  128'(bus.rcon_o),    128'h01);
    rst = 1'b0;

    // Known-answer column from the FIPS-197 MixColumns example.
    drive(1'b1, 1'b1, 1'b1);
    bus.g_in[127:96] = 32'hdb135345;
    bus.rkey_in = '0;
    step();
    check("fips_col0",  128'(bus.state_out[127:96]), 128'h8e4da1bc);
    check("fips_round", 128'(bus.round_o), 128'(2));
    drive(1'b0, 1'b0, 1'b1);
    step();

    // Rcon walk through a full block, then one idle cycle after the wrap.
    for (int b = 0; b < NR; b++) begin
      drive(1'b1, b == 0, 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 1'b1);
    step();

    // Backpressure then release.
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, b == 0, 1'b0);
      step();
    end
    for (int b = 0; b < 6; b++) begin
      drive(1'b1, 1'b0, 1'b1);
      step();
    end

    // Full throughput across a block boundary.
    for (int b = 0; b < 12; b++) begin
      drive(1'b1, b == 0, 1'b1);
      step();
    end

    // Restart at round 6.
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, b == 0, 1'b1);
      step();
    end
    drive(1'b1, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b1);
    step();

    // Random traffic.
    for (int b = 0; b < 300; b++) begin
      drive(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 3) != 0);
      step();
    end

    // Asynchronous reset at round 4 while holding data.
    drive(1'b1, 1'b1, 1'b1);
    step();
    for (int b = 0; b < NR && m_round != 4; b++) begin
      drive(1'b1, 1'b0, 1'b1);
      step();
    end
    check("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    rst = 1'b1;
    #2;
    check("arst_valid", 128'(bus.out_valid), 128'(0));
    check("arst_state", bus.state_out,       128'(0));
    check("arst_round", 128'(bus.round_o),   128'(1));
    check("arst_rcon",  128'(bus.rcon_o),    128'h01);
    model_reset();
    #1;
    rst = 1'b0;
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 1'b1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
